// File: rtl/binance_depth_types.sv
// binance_depth_types: shared types for the depth parser, sync controller and order book.
//   depth_event_t : normalised depth event; update_id is the exchange sequence key.
//   sync_state_e  : book synchronisation state.
//   seq_class_e   : classification of an event ID against a reference ID.
package binance_depth_types;

    typedef struct packed {
        logic [63:0] update_id;
        logic        is_bid;
        logic [31:0] price;
        logic [31:0] qty;
    } depth_event_t;

    localparam int EV_W = $bits(depth_event_t);

    typedef enum logic [1:0] {
        S_WAIT_SNAP = 2'd0,
        S_SNAP      = 2'd1,
        S_LIVE      = 2'd2,
        S_RESYNC    = 2'd3
    } sync_state_e;

    typedef enum logic [1:0] {
        SEQ_STALE = 2'd0,
        SEQ_SAME  = 2'd1,
        SEQ_NEXT  = 2'd2,
        SEQ_GAP   = 2'd3
    } seq_class_e;

endpackage

// File: rtl/book_sync_seq_check.sv
// book_sync_seq_check: classifies an event ID against a reference ID.
//   id        in  : event update ID
//   ref_id    in  : reference (snap_id or last_id)
//   seq_class out : SEQ_STALE / SEQ_SAME / SEQ_NEXT / SEQ_GAP
module book_sync_seq_check
    import binance_depth_types::*;
#(
    parameter int ID_WIDTH = 64
) (
    input  logic [ID_WIDTH-1:0] id,
    input  logic [ID_WIDTH-1:0] ref_id,
    output seq_class_e          seq_class
);

    logic [ID_WIDTH:0] ref_inc;

    // One extra bit so an all-ones reference has no representable successor.
    assign ref_inc = {1'b0, ref_id} + (ID_WIDTH+1)'(1);

    // With an all-ones reference any different ID is a discontinuity, never stale.
    always_comb
        seq_class = (id == ref_id)                  ? SEQ_SAME :
                    ({1'b0, id} == ref_inc)         ? SEQ_NEXT :
                    (ref_inc[ID_WIDTH] || id > ref_id) ? SEQ_GAP : SEQ_STALE;

endmodule

// File: rtl/book_sync_controller.sv
// book_sync_controller: gates depth events into the order book using snapshot-then-diff sequencing.
//   clk, rst_n (async, active-low)
//   in_valid/in_ev/in_snapshot : event from the parser
//   force_resync, resync_ack   : host resync control
//   out_valid/out_ev           : registered apply strobe and event to the book
//   book_clear                 : one-cycle book clear after a resync handshake
//   resync_req                 : level request for a new snapshot
//   sync_state                 : current sync_state_e
//   applied/dropped/gap_count  : statistics, built only when BOOK_SYNC_STATS_EN is defined
module book_sync_controller
    import binance_depth_types::*;
#(
    parameter int ID_WIDTH  = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [EV_W-1:0]      in_ev,
    input  logic                 in_snapshot,
    input  logic                 force_resync,
    input  logic                 resync_ack,
    output logic                 out_valid,
    output logic [EV_W-1:0]      out_ev,
    output logic                 book_clear,
    output logic                 resync_req,
    output logic [1:0]           sync_state,
    output logic [CNT_WIDTH-1:0] applied_count,
    output logic [CNT_WIDTH-1:0] dropped_count,
    output logic [CNT_WIDTH-1:0] gap_count
);

    depth_event_t        ev;
    logic [ID_WIDTH-1:0] id;
    logic [ID_WIDTH-1:0] ref_id;
    seq_class_e          seq_class;
    sync_state_e         state_q, state_d;
    logic [ID_WIDTH-1:0] last_id_q, last_id_d;
    logic [ID_WIDTH-1:0] snap_id_q, snap_id_d;
    logic                out_valid_q, out_valid_d;
    depth_event_t        out_ev_q, out_ev_d;
    logic                book_clear_q, book_clear_d;
    logic                apply, drop, gap;

    assign ev     = depth_event_t'(in_ev);
    assign id     = ev.update_id[ID_WIDTH-1:0];
    assign ref_id = (state_q == S_SNAP) ? snap_id_q : last_id_q;

    book_sync_seq_check #(.ID_WIDTH(ID_WIDTH)) u_seq_check (
        .id        (id),
        .ref_id    (ref_id),
        .seq_class (seq_class)
    );

    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        snap_id_d = snap_id_q;
        book_clear_d = 1'b0;
        apply = 1'b0;
        drop  = 1'b0;
        gap   = 1'b0;
        if (force_resync && state_q != S_RESYNC) begin
            state_d = S_RESYNC;
            drop    = in_valid;
        end else begin
            case (state_q)
                S_WAIT_SNAP: if (in_valid) begin
                    apply = in_snapshot;
                    drop  = !in_snapshot;
                    if (in_snapshot) begin
                        snap_id_d = id;
                        state_d   = S_SNAP;
                    end
                end
                S_SNAP: if (in_valid) begin
                    if (in_snapshot) begin
                        apply = seq_class == SEQ_SAME;
                        gap   = seq_class != SEQ_SAME;
                    end else begin
                        apply = seq_class == SEQ_NEXT;
                        gap   = seq_class == SEQ_GAP;
                    end
                    drop = !apply;
                    if (!in_snapshot && seq_class == SEQ_NEXT) begin
                        last_id_d = id;
                        state_d   = S_LIVE;
                    end
                    if (gap)
                        state_d = S_RESYNC;
                end
                S_LIVE: if (in_valid) begin
                    apply = !in_snapshot && (seq_class == SEQ_SAME || seq_class == SEQ_NEXT);
                    gap   = in_snapshot || seq_class == SEQ_GAP;
                    drop  = !apply;
                    if (apply)
                        last_id_d = id;
                    if (gap)
                        state_d = S_RESYNC;
                end
                default: begin
                    drop = in_valid;
                    if (resync_ack) begin
                        book_clear_d = 1'b1;
                        state_d      = S_WAIT_SNAP;
                    end
                end
            endcase
        end
        out_valid_d = apply;
        out_ev_d    = apply ? ev : out_ev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_WAIT_SNAP;
            last_id_q    <= '0;
            snap_id_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ev_q     <= '0;
            book_clear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_id_q    <= last_id_d;
            snap_id_q    <= snap_id_d;
            out_valid_q  <= out_valid_d;
            out_ev_q     <= out_ev_d;
            book_clear_q <= book_clear_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ev     = out_ev_q;
    assign book_clear = book_clear_q;
    assign resync_req = state_q == S_RESYNC;
    assign sync_state = state_q;

`ifdef BOOK_SYNC_STATS_EN
    logic [CNT_WIDTH-1:0] applied_q, applied_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;

    always_comb begin
        applied_d = applied_q + CNT_WIDTH'(apply);
        dropped_d = dropped_q + CNT_WIDTH'(drop);
        gap_d     = gap_q + CNT_WIDTH'(gap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            applied_q <= '0;
            dropped_q <= '0;
            gap_q     <= '0;
        end else begin
            applied_q <= applied_d;
            dropped_q <= dropped_d;
            gap_q     <= gap_d;
        end
    end

    assign applied_count = applied_q;
    assign dropped_count = dropped_q;
    assign gap_count     = gap_q;
`else
    logic unused_stats;
    assign unused_stats  = drop ^ gap;
    assign applied_count = '0;
    assign dropped_count = '0;
    assign gap_count     = '0;
`endif

endmodule

// File: tb/tb_book_sync_controller.sv
// tb_book_sync_controller: table-driven check of book_sync_controller sequencing, counters and reset.
module tb_book_sync_controller;
    import binance_depth_types::*;

`ifdef BOOK_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [EV_W-1:0] in_ev = '0;
    logic            in_snapshot = 1'b0;
    logic            force_resync = 1'b0;
    logic            resync_ack = 1'b0;
    logic            out_valid;
    logic [EV_W-1:0] out_ev;
    logic            book_clear;
    logic            resync_req;
    logic [1:0]      sync_state;
    logic [31:0]     applied_count, dropped_count, gap_count;

    book_sync_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ev         (in_ev),
        .in_snapshot   (in_snapshot),
        .force_resync  (force_resync),
        .resync_ack    (resync_ack),
        .out_valid     (out_valid),
        .out_ev        (out_ev),
        .book_clear    (book_clear),
        .resync_req    (resync_req),
        .sync_state    (sync_state),
        .applied_count (applied_count),
        .dropped_count (dropped_count),
        .gap_count     (gap_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic depth_event_t mk_ev(input logic [63:0] id);
        depth_event_t e;
        e.update_id = id;
        e.is_bid    = id[0];
        e.price     = id[31:0] + 32'd1;
        e.qty       = 32'h55;
        return e;
    endfunction

    typedef struct {
        logic        v, s, f, a;
        logic [63:0] id;
        logic        ov;
        logic [1:0]  st;
        logic        rr, bc;
        int          ea, ed, eg;
    } vec_t;

    function automatic vec_t mv(input logic v, s, f, a, input logic [63:0] id, input logic ov,
                                input logic [1:0] st, input logic rr, bc, input int ea, ed, eg);
        vec_t t;
        t.v = v; t.s = s; t.f = f; t.a = a; t.id = id; t.ov = ov;
        t.st = st; t.rr = rr; t.bc = bc; t.ea = ea; t.ed = ed; t.eg = eg;
        return t;
    endfunction

    task automatic chk_cnt(input string tag, input int ea, input int ed, input int eg);
        chk({tag, " applied"}, 256'(applied_count), STATS ? 256'(ea) : 256'd0);
        chk({tag, " dropped"}, 256'(dropped_count), STATS ? 256'(ed) : 256'd0);
        chk({tag, " gap"},     256'(gap_count),     STATS ? 256'(eg) : 256'd0);
    endtask

    vec_t         tv[29];
    depth_event_t exp_ev;

    initial begin
        // valid snap force ack id | out_valid state resync_req book_clear | applied dropped gap
        tv[0]  = mv(1,0,0,0, 64'd5,   0, 2'd0, 0, 0,  0,  1, 0);
        tv[1]  = mv(1,0,0,0, 64'd6,   0, 2'd0, 0, 0,  0,  2, 0);
        tv[2]  = mv(1,0,0,0, 64'd7,   0, 2'd0, 0, 0,  0,  3, 0);
        tv[3]  = mv(1,1,0,0, 64'd100, 1, 2'd1, 0, 0,  1,  3, 0);
        tv[4]  = mv(1,1,0,0, 64'd100, 1, 2'd1, 0, 0,  2,  3, 0);
        tv[5]  = mv(1,1,0,0, 64'd100, 1, 2'd1, 0, 0,  3,  3, 0);
        tv[6]  = mv(1,1,0,0, 64'd100, 1, 2'd1, 0, 0,  4,  3, 0);
        tv[7]  = mv(1,0,0,0, 64'd99,  0, 2'd1, 0, 0,  4,  4, 0);
        tv[8]  = mv(1,0,0,0, 64'd100, 0, 2'd1, 0, 0,  4,  5, 0);
        tv[9]  = mv(1,0,0,0, 64'd101, 1, 2'd2, 0, 0,  5,  5, 0);
        tv[10] = mv(1,0,0,0, 64'd101, 1, 2'd2, 0, 0,  6,  5, 0);
        tv[11] = mv(1,0,0,0, 64'd102, 1, 2'd2, 0, 0,  7,  5, 0);
        tv[12] = mv(1,0,0,0, 64'd100, 0, 2'd2, 0, 0,  7,  6, 0);
        tv[13] = mv(1,0,0,0, 64'd104, 0, 2'd3, 1, 0,  7,  7, 1);
        tv[14] = mv(1,0,0,0, 64'd105, 0, 2'd3, 1, 0,  7,  8, 1);
        tv[15] = mv(1,1,0,1, 64'd200, 0, 2'd0, 0, 1,  7,  9, 1);
        tv[16] = mv(0,0,0,0, 64'd0,   0, 2'd0, 0, 0,  7,  9, 1);
        tv[17] = mv(1,1,0,0, 64'd200, 1, 2'd1, 0, 0,  8,  9, 1);
        tv[18] = mv(1,0,0,0, 64'd201, 1, 2'd2, 0, 0,  9,  9, 1);
        tv[19] = mv(1,0,1,1, 64'd202, 0, 2'd3, 1, 0,  9, 10, 1);
        tv[20] = mv(0,0,0,0, 64'd0,   0, 2'd3, 1, 0,  9, 10, 1);
        tv[21] = mv(0,0,0,1, 64'd0,   0, 2'd0, 0, 1,  9, 10, 1);
        tv[22] = mv(1,1,0,0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 2'd1, 0, 0, 10, 10, 1);
        tv[23] = mv(1,0,0,0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'd2, 0, 0, 11, 10, 1);
        tv[24] = mv(1,0,0,0, 64'd0,   0, 2'd3, 1, 0, 11, 11, 2);
        tv[25] = mv(0,0,0,1, 64'd0,   0, 2'd0, 0, 1, 11, 11, 2);
        tv[26] = mv(1,1,0,0, 64'd50,  1, 2'd1, 0, 0, 12, 11, 2);
        tv[27] = mv(1,1,0,0, 64'd51,  0, 2'd3, 1, 0, 12, 12, 3);
        tv[28] = mv(0,0,0,1, 64'd0,   0, 2'd0, 0, 1, 12, 12, 3);

        exp_ev = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 256'(out_valid), 256'd0);
        chk("rst state", 256'(sync_state), 256'd0);
        chk("rst resync_req", 256'(resync_req), 256'd0);
        chk("rst book_clear", 256'(book_clear), 256'd0);
        chk("rst out_ev", 256'(out_ev), 256'd0);
        chk_cnt("rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) begin
            in_valid     = tv[i].v;
            in_snapshot  = tv[i].s;
            force_resync = tv[i].f;
            resync_ack   = tv[i].a;
            in_ev        = mk_ev(tv[i].id);
            @(posedge clk);
            #1;
            if (tv[i].ov)
                exp_ev = mk_ev(tv[i].id);
            chk($sformatf("v%0d out_valid", i), 256'(out_valid), 256'(tv[i].ov));
            chk($sformatf("v%0d state", i), 256'(sync_state), 256'(tv[i].st));
            chk($sformatf("v%0d resync_req", i), 256'(resync_req), 256'(tv[i].rr));
            chk($sformatf("v%0d book_clear", i), 256'(book_clear), 256'(tv[i].bc));
            chk($sformatf("v%0d out_ev", i), 256'(out_ev), 256'(exp_ev));
            chk_cnt($sformatf("v%0d", i), tv[i].ea, tv[i].ed, tv[i].eg);
        end

        // Asynchronous reset mid-burst: snapshot applied, next diff in flight.
        in_valid = 1'b1; in_snapshot = 1'b1; force_resync = 1'b0; resync_ack = 1'b0;
        in_ev = mk_ev(64'd7);
        @(posedge clk);
        #1;
        chk("burst snap out_valid", 256'(out_valid), 256'd1);
        chk("burst snap state", 256'(sync_state), 256'd1);
        in_snapshot = 1'b0;
        in_ev = mk_ev(64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 256'(out_valid), 256'd0);
        chk("async state", 256'(sync_state), 256'd0);
        chk("async out_ev", 256'(out_ev), 256'd0);
        chk("async resync_req", 256'(resync_req), 256'd0);
        chk("async book_clear", 256'(book_clear), 256'd0);
        chk_cnt("async", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_ev = mk_ev(64'd9);
        @(posedge clk);
        #1;
        chk("post rst diff out_valid", 256'(out_valid), 256'd0);
        chk("post rst diff state", 256'(sync_state), 256'd0);
        chk_cnt("post rst", 0, 1, 0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
